// File: rtl/ifu_fq_pkg.sv
// rtl/ifu_fq_pkg.sv - ifu_fq configuration defaults, fetch queue entry type, width helper
package ifu_fq_pkg;

  localparam int unsigned FQ_DEPTH_DEF = 4;
  localparam int unsigned MAX_OS_DEF   = 2;
  localparam int unsigned XLEN_DEF     = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
    logic                bp_taken;
    logic [XLEN_DEF-1:0] bp_pc;
  } fq_entry_t;

  // Width of an occupancy counter that must be able to hold the value depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_fq_if.sv
// rtl/ifu_fq_if.sv - ifu_fq imem, branch predictor and decoder handshake bundle
interface ifu_fq_if
  import ifu_fq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic [XLEN-1:0] bp_req_pc;
  logic            bp_resp_valid;
  logic [XLEN-1:0] bp_resp_pc;
  logic            fq_valid;
  logic            fq_ready;
  logic [XLEN-1:0] fq_pc;
  logic [XLEN-1:0] fq_pc_plus;
  logic [XLEN-1:0] fq_inst;
  logic            fq_bp_taken;
  logic [XLEN-1:0] fq_bp_pc;

  modport master (
    output imem_req_valid, imem_req_addr, bp_req_pc,
           fq_valid, fq_pc, fq_pc_plus, fq_inst, fq_bp_taken, fq_bp_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           bp_resp_valid, bp_resp_pc, fq_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, bp_req_pc,
           fq_valid, fq_pc, fq_pc_plus, fq_inst, fq_bp_taken, fq_bp_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           bp_resp_valid, bp_resp_pc, fq_ready
  );
endinterface

// File: rtl/ifu_fq_fifo.sv
// rtl/ifu_fq_fifo.sv - ifu_fifo: generic synchronous FIFO with clear, registered storage
module ifu_fifo
  import ifu_fq_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rptr_q];
  assign do_pop   = pop & ~empty;
  // A pop frees the slot in the same cycle, so push at full is accepted alongside it.
  assign do_push  = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wptr_d = bump(wptr_q);
    if (do_pop)  rptr_d = bump(rptr_q);
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q] <= push_data;
  end
endmodule

// File: rtl/ifu_fq.sv
// rtl/ifu_fq.sv - decoupled instruction fetch with outstanding-request credits and fetch queue
// Optional IFU_PERF_CNT_EN adds saturating delivered/discarded response counters.
module ifu_fq
  import ifu_fq_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int unsigned MAX_OS   = MAX_OS_DEF,
  parameter int unsigned XLEN     = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] rst_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  ifu_fq_if.master        bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);
  localparam int unsigned OW = cnt_width(MAX_OS);
  localparam int unsigned QW = cnt_width(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            bp_taken;
    logic [XLEN-1:0] bp_pc;
  } tag_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            bp_taken;
    logic [XLEN-1:0] bp_pc;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d, req_addr;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d, os_cnt;
  logic [QW-1:0]   fq_count;
  logic            req_valid, issue, resp, keep, fq_pop;
  logic            tag_full, tag_empty, fq_full, fq_empty;
  tag_t            tag_wdata, tag_rdata;
  entry_t          fq_wdata, fq_head;

  assign req_addr  = {pc_q[XLEN-1:2], 2'b00};
  // Credit covers both in-flight reads and queued entries, so every response has a slot.
  assign req_valid = rstn & ~flush & ~tag_full &
                     ((32'(os_cnt) + 32'(fq_count)) < FQ_DEPTH);
  assign issue     = req_valid & bus.imem_req_ready;
  assign resp      = bus.imem_resp_valid;
  assign keep      = resp & (drop_cnt_q == '0) & ~flush;
  assign fq_pop    = bus.fq_ready & ~fq_empty;

  assign tag_wdata = '{pc: req_addr, bp_taken: bus.bp_resp_valid, bp_pc: bus.bp_resp_pc};
  assign fq_wdata  = '{pc: tag_rdata.pc, inst: bus.imem_resp_data,
                       bp_taken: tag_rdata.bp_taken, bp_pc: tag_rdata.bp_pc};

  // The tag FIFO occupancy is the outstanding-request count; drops still pop it.
  ifu_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_OS)) u_tag (
    .clk(clk), .rstn(rstn), .clr(1'b0),
    .push(issue), .push_data(tag_wdata),
    .pop(resp), .pop_data(tag_rdata),
    .count(os_cnt), .empty(tag_empty), .full(tag_full)
  );

  ifu_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FQ_DEPTH)) u_fq (
    .clk(clk), .rstn(rstn), .clr(flush),
    .push(keep), .push_data(fq_wdata),
    .pop(fq_pop), .pop_data(fq_head),
    .count(fq_count), .empty(fq_empty), .full(fq_full)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush)      pc_d = flush_pc;
    else if (issue) pc_d = bus.bp_resp_valid ? bus.bp_resp_pc : req_addr + XLEN'(4);
  end

  // Reloading from os_cnt on every flush keeps a second flush from double-counting drops.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush)                         drop_cnt_d = os_cnt - OW'(resp);
    else if (resp && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= rst_pc;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.bp_req_pc      = req_addr;
  assign bus.fq_valid       = ~fq_empty;
  assign bus.fq_pc          = fq_empty ? '0 : fq_head.pc;
  assign bus.fq_pc_plus     = fq_empty ? '0 : fq_head.pc + XLEN'(4);
  assign bus.fq_inst        = fq_empty ? '0 : fq_head.inst;
  assign bus.fq_bp_taken    = ~fq_empty & fq_head.bp_taken;
  assign bus.fq_bp_pc       = fq_empty ? '0 : fq_head.bp_pc;

  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rstn) resp |-> !tag_empty);
  a_fq_no_overflow:   assert property (@(posedge clk) disable iff (!rstn) !(keep && fq_full && !fq_pop));

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d, perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_drop_cnt_d  = perf_drop_cnt_q;
    if (keep && perf_fetch_cnt_q != '1)        perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
    if (resp && !keep && perf_drop_cnt_q != '1) perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_cnt_q <= '0;
      perf_drop_cnt_q  <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_drop_cnt_q  <= perf_drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_drop_cnt  = perf_drop_cnt_q;
`endif
endmodule

// File: tb/tb_ifu_fq.sv
// tb/tb_ifu_fq.sv - randomized scoreboard bench for ifu_fq against a queue-level fetch model
module tb_ifu_fq;
  import ifu_fq_pkg::*;

  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned MAX_OS   = 2;
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] rst_pc = RST_PC;
  logic [31:0] flush_pc = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ifu_fq_if #(.XLEN(XLEN)) bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  ifu_fq #(.FQ_DEPTH(FQ_DEPTH), .MAX_OS(MAX_OS), .XLEN(XLEN)) dut (
    .clk(clk),
    .rstn(rstn),
    .rst_pc(rst_pc),
    .flush(flush),
    .flush_pc(flush_pc),
    .bus(bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  // Model: requests in flight (tagged with the flush epoch they were issued in) and
  // the instruction stream the decoder should see, in order.
  typedef struct {
    logic [31:0] pc;
    logic        bp_taken;
    logic [31:0] bp_pc;
    logic [31:0] inst;
    int          epoch;
  } flight_t;

  flight_t     inflight[$];
  fq_entry_t   sb[$];
  logic [31:0] model_pc;
  int          epoch = 0;
  int          n_fetch = 0;
  int          n_drop = 0;
  logic        prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    flush                = 1'b0;
    flush_pc             = '0;
    bus.imem_req_ready   = 1'b0;
    bus.imem_resp_valid  = 1'b0;
    bus.imem_resp_data   = '0;
    bus.bp_resp_valid    = 1'b0;
    bus.bp_resp_pc       = '0;
    bus.fq_ready         = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    quiet_inputs();
    rst_pc = pc;
    rstn   = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr", bus.imem_req_addr, pc);
    chk("rst_bp_req_pc", bus.bp_req_pc, pc);
    chk("rst_fq_valid", bus.fq_valid, 0);
    chk("rst_fq_pc", bus.fq_pc, 0);
    chk("rst_fq_pc_plus", bus.fq_pc_plus, 0);
    chk("rst_fq_inst", bus.fq_inst, 0);
    chk("rst_fq_bp_taken", bus.fq_bp_taken, 0);
    chk("rst_fq_bp_pc", bus.fq_bp_pc, 0);
    inflight.delete();
    sb.delete();
    model_pc   = pc;
    prev_stall = 1'b0;
    n_fetch    = 0;
    n_drop     = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock of random stimulus; each argument is the percent chance of its input being asserted.
  task automatic cycle(input int p_rdy, input int p_resp, input int p_bp, input int p_fl, input int p_fqr);
    flight_t     f;
    fq_entry_t   e;
    logic        exp_valid;
    logic [31:0] aligned;
    @(negedge clk);
    bus.imem_req_ready  = ($urandom_range(99) < p_rdy);
    bus.bp_resp_valid   = ($urandom_range(99) < p_bp);
    bus.bp_resp_pc      = bus.bp_resp_valid ? $urandom : 32'h0;
    flush               = ($urandom_range(99) < p_fl);
    flush_pc            = $urandom;
    bus.fq_ready        = ($urandom_range(99) < p_fqr);
    bus.imem_resp_valid = (inflight.size() > 0) && ($urandom_range(99) < p_resp);
    bus.imem_resp_data  = bus.imem_resp_valid ? inflight[0].inst : $urandom;
    #1;
    exp_valid = !flush && (inflight.size() < MAX_OS) && (inflight.size() + sb.size() < FQ_DEPTH);
    aligned   = {model_pc[31:2], 2'b00};
    chk("req_valid", bus.imem_req_valid, exp_valid);
    if (prev_stall && !flush) chk("req_hold", bus.imem_req_valid, 1);
    if (exp_valid) begin
      chk("req_addr", bus.imem_req_addr, aligned);
      chk("bp_req_pc", bus.bp_req_pc, aligned);
    end
    prev_stall = exp_valid && !bus.imem_req_ready;
    if (flush) begin
      epoch++;
      sb.delete();
      model_pc = flush_pc;
    end
    if (bus.imem_resp_valid) begin
      f = inflight.pop_front();
      if (f.epoch == epoch) begin
        e.pc = f.pc; e.inst = f.inst; e.bp_taken = f.bp_taken; e.bp_pc = f.bp_pc;
        sb.push_back(e);
        n_fetch++;
      end else begin
        n_drop++;
      end
    end
    if (exp_valid && bus.imem_req_ready) begin
      f.pc = aligned; f.bp_taken = bus.bp_resp_valid; f.bp_pc = bus.bp_resp_pc;
      f.inst = $urandom; f.epoch = epoch;
      inflight.push_back(f);
      model_pc = bus.bp_resp_valid ? bus.bp_resp_pc : aligned + 32'd4;
    end
  endtask

  // Monitor: whenever the decoder takes the head, it must match the oldest expected entry.
  initial begin
    fq_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && bus.fq_valid && bus.fq_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("fq_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("fq_pc", bus.fq_pc, e.pc);
          chk("fq_pc_plus", bus.fq_pc_plus, e.pc + 32'd4);
          chk("fq_inst", bus.fq_inst, e.inst);
          chk("fq_bp_taken", bus.fq_bp_taken, e.bp_taken);
          chk("fq_bp_pc", bus.fq_bp_pc, e.bp_pc);
        end
      end
    end
  end

  initial begin
    int guard;
    quiet_inputs();
    #1 rstn = 1'b0;
    do_reset(RST_PC);
    repeat (30) cycle(100, 100, 0, 0, 100);
    repeat (40) cycle(100, 100, 50, 0, 100);
    repeat (12) cycle(100, 100, 0, 0, 0);
    chk("fill_depth", sb.size(), FQ_DEPTH);
    chk("fill_inflight", inflight.size(), 0);
    repeat (6) cycle(100, 100, 0, 0, 100);
    repeat (60) cycle(30, 60, 20, 0, 70);
    repeat (300) cycle(70, 60, 25, 10, 70);
    do_reset(32'h0000_1000);
    repeat (300) cycle(60, 50, 30, 8, 60);
    guard = 0;
    while ((inflight.size() > 0 || sb.size() > 0) && guard < 100) begin
      cycle(0, 100, 0, 0, 100);
      guard++;
    end
    chk("drain_done", (inflight.size() == 0 && sb.size() == 0), 1);
    cycle(0, 100, 0, 0, 100);
    chk("drain_fq_valid", bus.fq_valid, 0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, n_fetch);
    chk("perf_drop_cnt", perf_drop_cnt, n_drop);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifu_fq.md
Name: ifu_fq

Overview:
- Parametrised next-generation instruction fetch unit: decoupled request/response fetch with up to MAX_OS outstanding imem reads and a FQ_DEPTH-entry fetch queue feeding the decoder over a valid/ready handshake.
- Sits between the pc/bpu and idu.
- Replaces the single-request, response-implied fetch.
- Handles flush with in-flight response squashing.

Parameters:
- FQ_DEPTH, 4, fetch queue entries (power of 2, >=2)
- MAX_OS, 2, max outstanding imem requests (1..FQ_DEPTH)
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- rst_pc  in  XLEN  pc loaded at reset
- flush  in  1  redirect pipeline
- flush_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_resp_valid  in  1  fetch data return, in-order, always accepted
- imem_resp_data  in  XLEN  instruction word
- bp_req_pc  out  XLEN  equals imem_req_addr
- bp_resp_valid  in  1  predicted taken for bp_req_pc, same cycle
- bp_resp_pc  in  XLEN  predicted target
- fq_valid  out  1  head entry valid
- fq_ready  in  1  decoder consumes head
- fq_pc  out  XLEN  head pc
- fq_pc_plus  out  XLEN  head pc+4
- fq_inst  out  XLEN  head instruction
- fq_bp_taken  out  1  head was predicted taken
- fq_bp_pc  out  XLEN  head predicted target

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on rstn.
- Reset values:
  - pc=rst_pc; queue empty; os_cnt=0; drop_cnt=0.
  - All outputs 0 except imem_req_addr=bp_req_pc=rst_pc.
  - imem_req_valid is 0 during reset, 1 the first cycle after.
- Issue rule:
  - imem_req_valid = ~flush & (os_cnt < MAX_OS) & (os_cnt + fq_count < FQ_DEPTH). This credit rule guarantees space for every response; the queue never overflows.
  - imem_req_valid stays asserted with stable addr until ready.
- Next pc:
  - On issue handshake: pc <= bp_resp_valid ? bp_resp_pc : pc+4.
  - The pc's bp_taken/bp_pc are pushed into an os tag FIFO (depth MAX_OS).
  - Without a handshake, pc holds.
- Response:
  - If drop_cnt==0, each imem_resp_valid pops the tag FIFO and writes {pc, inst, bp} into the fetch queue tail.
  - If drop_cnt>0, it pops the tag and discards; drop_cnt decrements.
- Latency:
  - Response is visible at fq_valid the cycle after imem_resp_valid (registered queue).
  - Minimum request-to-decode latency is 2 cycles with a 1-cycle memory.
- Output handshake: pop the head when fq_valid & fq_ready. Simultaneous push and pop is allowed at full or empty.
- Counters:
  - os_cnt +1 on issue handshake, -1 on any response; both in the same cycle leaves it unchanged.
  - fq_count wraps pointers modulo FQ_DEPTH.
- Flush (highest priority):
  - pc <= flush_pc; queue cleared; fq_valid=0 the next cycle.
  - No request issues in the flush cycle.
  - drop_cnt <= os_cnt minus (1 if a response arrives that same cycle); that response is discarded.
  - os_cnt is not cleared: drops still decrement it on return.
  - A flush while drop_cnt>0 loads the same formula, never double-counting.
- Ordering: responses are strictly in request order; no response without an outstanding request (imem_resp_valid with os_cnt==0 is illegal; assertion).
- Alignment: imem_req_addr[1:0] is forced 0.
- Reset mid-operation: all state clears immediately; responses arriving after reset are illegal (imem is reset jointly).

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetch_cnt (32b, +1 per accepted-into-queue response) and perf_drop_cnt (32b, +1 per discarded response).
  - Both reset to 0 and saturate at all-ones.
- When undefined: the ports and counters are absent; function is otherwise identical.

Decomposition:
- urv_cfg package: FQ_DEPTH/MAX_OS defaults.
- urv_typedef package: fq_entry_t {pc, inst, bp_taken, bp_pc}.
- Sub-module: generic sync FIFO ifu_fifo (parameter width/depth, push/pop/count), used twice: tag FIFO and fetch queue.

Test Plan:
- Reset with rst_pc=0x8000_0000, imem always ready, 1-cycle response, fq_ready=1 → requests 0x8000_0000, 0x8000_0004, 0x8000_0008… issued back to back; fq_pc follows the same sequence, 2 cycles after its request.
- fq_ready=0, FQ_DEPTH=4, MAX_OS=2 → exactly 4 requests issue, then imem_req_valid=0; fq_count=4, no overflow. Releasing fq_ready resumes issue the cycle after the first pop.
- bp_resp_valid=1, bp_resp_pc=0x8000_0100 while requesting 0x8000_0004:
  - next request is 0x8000_0100;
  - head for 0x8000_0004 has fq_bp_taken=1, fq_bp_pc=0x8000_0100.
- Two requests outstanding, flush to 0x8000_0200 in the cycle one response returns:
  - that response and the next are discarded (drop_cnt=1);
  - the first fq_pc seen is 0x8000_0200; os_cnt returns to 0.
- imem_req_ready held low 5 cycles → imem_req_valid/addr stable throughout; no duplicate fetch.
- IFU_PERF_CNT_EN defined, the flush scenario above → perf_drop_cnt=2, perf_fetch_cnt counts only delivered entries.
